// File: rtl/bch_encoder_63_56_if.sv
// Valid/ready bundle between a message source, the BCH(63,56) encoder and its sink.
// The error-injection controls exist only when BCH_ERR_INJECT_EN is defined.
interface bch_encoder_63_56_if;
   localparam int unsigned MSG_W = 56;
   localparam int unsigned CW_W  = 63;
   localparam int unsigned POS_W = 6;

   logic             in_valid;
   logic             in_ready;
   logic [MSG_W-1:0] msg;
   logic             out_valid;
   logic             out_ready;
   logic [CW_W-1:0]  codeword;
   logic             busy;
`ifdef BCH_ERR_INJECT_EN
   logic             err_en;
   logic [POS_W-1:0] err_pos;

   modport master (
      output in_valid, msg, out_ready, err_en, err_pos,
      input  in_ready, out_valid, codeword, busy
   );

   modport slave (
      input  in_valid, msg, out_ready, err_en, err_pos,
      output in_ready, out_valid, codeword, busy
   );
`else
   modport master (
      output in_valid, msg, out_ready,
      input  in_ready, out_valid, codeword, busy
   );

   modport slave (
      input  in_valid, msg, out_ready,
      output in_ready, out_valid, codeword, busy
   );
`endif
endinterface

// File: rtl/bch_encoder_63_56.sv
// Systematic BCH(63,56) encoder: W message bits per cycle through an LFSR over g(x)=x^7+x^6+x^2+1.
// Define BCH_ERR_INJECT_EN to add err_en/err_pos for single-bit error injection on the codeword.
module bch_encoder_63_56 #(
   parameter int unsigned K     = 56,
   parameter int unsigned P     = 7,
   parameter logic [6:0]  GPOLY = 7'b1000101,
   parameter int unsigned W     = 1
) (
   input logic                clk,
   input logic                rst,
   bch_encoder_63_56_if.slave bus
);
   localparam int unsigned N      = K + P;
   localparam int unsigned NCHUNK = K / W;
   localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);
   localparam int unsigned POS_W  = 6;

   if (K != 56) begin : g_bad_k
      $error("bch_encoder_63_56: K must be 56");
   end
   if (P != 7) begin : g_bad_p
      $error("bch_encoder_63_56: P must be 7");
   end
   if ((K % W) != 0) begin : g_bad_div
      $error("bch_encoder_63_56: K must be a multiple of W");
   end
   if (!(W == 1 || W == 2 || W == 4 || W == 7 || W == 8)) begin : g_bad_w
      $error("bch_encoder_63_56: W must be one of 1,2,4,7,8");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [K-1:0]     msg_q, msg_n;
   logic [K-1:0]     shreg, shreg_n;
   logic [P-1:0]     lfsr, lfsr_n, lfsr_step;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [N-1:0]     codeword_q, codeword_n;
   logic             in_ready_q, in_ready_n;
   logic             out_valid_q, out_valid_n;
   logic             busy_q, busy_n;
`ifdef BCH_ERR_INJECT_EN
   logic [N-1:0]     err_mask_q, err_mask_n;
`endif

   // W chained LFSR steps consume the next W message bits, MSB first
   always_comb begin : lfsr_chunk
      logic fb;
      fb        = 1'b0;
      lfsr_step = lfsr;
      for (int i = 0; i < int'(W); i++) begin
         fb        = shreg[K-1-i] ^ lfsr_step[P-1];
         lfsr_step = {lfsr_step[P-2:0], 1'b0} ^ (fb ? GPOLY : P'(0));
      end
   end

   always_comb begin : fsm_next
      state_n     = state;
      msg_n       = msg_q;
      shreg_n     = shreg;
      lfsr_n      = lfsr;
      cnt_n       = cnt;
      codeword_n  = codeword_q;
      in_ready_n  = in_ready_q;
      out_valid_n = out_valid_q;
      busy_n      = busy_q;
`ifdef BCH_ERR_INJECT_EN
      err_mask_n  = err_mask_q;
`endif
      unique case (state)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               msg_n      = bus.msg;
               shreg_n    = bus.msg;
               lfsr_n     = '0;
               cnt_n      = '0;
               in_ready_n = 1'b0;
               busy_n     = 1'b1;
               state_n    = SHIFT;
`ifdef BCH_ERR_INJECT_EN
               err_mask_n = '0;
               if (bus.err_en && (bus.err_pos != POS_W'(63))) begin
                  err_mask_n = N'(1) << bus.err_pos;
               end
`endif
            end
         end
         SHIFT: begin
            shreg_n = shreg << W;
            lfsr_n  = lfsr_step;
            cnt_n   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(NCHUNK - 1)) begin
`ifdef BCH_ERR_INJECT_EN
               codeword_n = {msg_q, lfsr_step} ^ err_mask_q;
`else
               codeword_n = {msg_q, lfsr_step};
`endif
               out_valid_n = 1'b1;
               busy_n      = 1'b0;
               state_n     = DONE;
            end
         end
         DONE: begin
            // codeword stays frozen until the sink takes it; accept reopens next cycle
            if (bus.out_ready) begin
               out_valid_n = 1'b0;
               in_ready_n  = 1'b1;
               state_n     = IDLE;
            end
         end
         default: begin
            state_n     = IDLE;
            in_ready_n  = 1'b1;
            out_valid_n = 1'b0;
            busy_n      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         msg_q       <= '0;
         shreg       <= '0;
         lfsr        <= '0;
         cnt         <= '0;
         codeword_q  <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef BCH_ERR_INJECT_EN
         err_mask_q  <= '0;
`endif
      end else begin
         state       <= state_n;
         msg_q       <= msg_n;
         shreg       <= shreg_n;
         lfsr        <= lfsr_n;
         cnt         <= cnt_n;
         codeword_q  <= codeword_n;
         in_ready_q  <= in_ready_n;
         out_valid_q <= out_valid_n;
         busy_q      <= busy_n;
`ifdef BCH_ERR_INJECT_EN
         err_mask_q  <= err_mask_n;
`endif
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.codeword  = codeword_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_bch_encoder_63_56.sv
// Scoreboard bench for bch_encoder_63_56: random lanes for every legal W plus directed W=1/W=8 scenarios.
module tb_bch_encoder_63_56;
   localparam int unsigned NRAND = 1000;
   localparam logic [7:0]  GFULL = 8'hC5;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic rst_d = 1'b1;
   int   checks     = 0;
   int   errors     = 0;
   int   lanes_done = 0;

   always #5 clk = ~clk;

   // remainder of v(x) divided by g(x) by long division
   function automatic logic [6:0] poly_mod(input logic [62:0] v);
      logic [62:0] d;
      d = v;
      for (int k = 62; k >= 7; k--) begin
         if (d[k]) d = d ^ (63'(GFULL) << (k - 7));
      end
      return d[6:0];
   endfunction

   function automatic logic [62:0] ref_cw(input logic [55:0] m);
      return {m, poly_mod({m, 7'b0})};
   endfunction

   task automatic check(input string name, input logic [62:0] act, input logic [62:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- random lanes, one per legal W ----------------
   for (genvar g = 0; g < 5; g++) begin : g_lane
      localparam int unsigned LW = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 7 : 8;
      bch_encoder_63_56_if bus ();
      bch_encoder_63_56 #(.W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));
      logic [62:0] exp_q[$];

      initial begin : drive
         logic [55:0] m;
         int waited;
         bus.in_valid = 1'b0;
         bus.msg      = '0;
`ifdef BCH_ERR_INJECT_EN
         bus.err_en   = 1'b0;
         bus.err_pos  = '0;
`endif
         @(negedge clk);
         while (rst) @(negedge clk);
         for (int n = 0; n < NRAND; n++) begin
            m            = {24'($urandom), $urandom};
            bus.msg      = m;
            bus.in_valid = 1'b1;
            waited       = 0;
            while (!bus.in_ready && waited < 300) begin
               @(negedge clk);
               waited++;
            end
            if (!bus.in_ready) begin
               checks++;
               errors++;
               $display("FAIL lane_w%0d_accept_timeout: in_ready=%b, expected 1", LW, bus.in_ready);
               break;
            end
            exp_q.push_back(ref_cw(m));
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.msg      = {24'($urandom), $urandom};
            if ($urandom_range(1) == 1) @(negedge clk);
         end
      end

      initial begin : monitor
         logic [62:0] e;
         int got;
         int idle;
         got           = 0;
         idle          = 0;
         bus.out_ready = 1'b0;
         while (got < int'(NRAND) && idle < 2000) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(7) != 0);
            if (!rst && bus.out_valid && bus.out_ready) begin
               idle = 0;
               got++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL lane_w%0d_unexpected: got %h, expected no output", LW, bus.codeword);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("lane_w%0d_codeword", LW), bus.codeword, e);
                  check($sformatf("lane_w%0d_syndrome", LW), 63'(poly_mod(bus.codeword)), 63'(0));
               end
            end else begin
               idle++;
            end
         end
         if (got < int'(NRAND)) begin
            checks++;
            errors++;
            $display("FAIL lane_w%0d_timeout: got %0d codewords, expected %0d", LW, got, NRAND);
         end
         lanes_done++;
      end
   end

   // ---------------- directed instances ----------------
   bch_encoder_63_56_if bd1 ();
   bch_encoder_63_56_if bd8 ();
   bch_encoder_63_56 #(.W(1)) dut1 (.clk(clk), .rst(rst_d), .bus(bd1));
   bch_encoder_63_56 #(.W(8)) dut8 (.clk(clk), .rst(rst_d), .bus(bd8));
   logic [62:0] dq1[$];

   initial begin : mon_d1
      logic [62:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_d && bd1.out_valid && bd1.out_ready) begin
            if (dq1.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL d1_unexpected: got %h, expected no output", bd1.codeword);
            end else begin
               e = dq1.pop_front();
               check("d1_codeword", bd1.codeword, e);
            end
         end
      end
   end

   task automatic d_accept(input logic [55:0] m);
      logic [62:0] e;
      int waited;
      bd1.msg      = m;
      bd1.in_valid = 1'b1;
      waited       = 0;
      while (!bd1.in_ready && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      check("d1_accept_ready", 63'(bd1.in_ready), 63'(1));
      e = ref_cw(m);
`ifdef BCH_ERR_INJECT_EN
      if (bd1.err_en && bd1.err_pos != 6'd63) e[bd1.err_pos] = ~e[bd1.err_pos];
`endif
      dq1.push_back(e);
      @(negedge clk);
      bd1.in_valid = 1'b0;
      bd1.msg      = '1;
   endtask

   task automatic d_wait_out(output int lat);
      lat = 0;
      while (!bd1.out_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin : main
      logic [62:0] held;
      logic [55:0] m;
      int lat;
      int seen;
      int waited;
      bd1.in_valid  = 1'b0;
      bd1.msg       = '0;
      bd1.out_ready = 1'b0;
      bd8.in_valid  = 1'b0;
      bd8.msg       = '0;
      bd8.out_ready = 1'b0;
`ifdef BCH_ERR_INJECT_EN
      bd1.err_en  = 1'b0;
      bd1.err_pos = '0;
      bd8.err_en  = 1'b0;
      bd8.err_pos = '0;
`endif
      repeat (2) @(negedge clk);
      check("rst_in_ready", 63'(bd1.in_ready), 63'(1));
      check("rst_out_valid", 63'(bd1.out_valid), 63'(0));
      check("rst_busy", 63'(bd1.busy), 63'(0));
      check("rst_codeword", bd1.codeword, 63'(0));
      rst   = 1'b0;
      rst_d = 1'b0;
      @(negedge clk);

      // all-zero message, W=1 latency
      bd1.out_ready = 1'b1;
      d_accept(56'h0);
      check("shift_busy", 63'(bd1.busy), 63'(1));
      check("shift_in_ready", 63'(bd1.in_ready), 63'(0));
      d_wait_out(lat);
      check("lat_w1", 63'(lat), 63'(56));
      check("done_busy", 63'(bd1.busy), 63'(0));
      check("cw_zero", bd1.codeword, 63'h0);

      d_accept(56'h1);
      d_wait_out(lat);
      check("cw_msg1_w1", bd1.codeword, 63'h0C5);

      // single-bit message on the W=8 instance
      bd8.out_ready = 1'b1;
      bd8.msg       = 56'h1;
      bd8.in_valid  = 1'b1;
      waited        = 0;
      while (!bd8.in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      @(negedge clk);
      bd8.in_valid = 1'b0;
      lat          = 0;
      while (!bd8.out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("lat_w8", 63'(lat), 63'(7));
      check("cw_msg1_w8", bd8.codeword, 63'h0C5);

      // backpressure
      bd1.out_ready = 1'b0;
      m = {24'($urandom), $urandom};
      d_accept(m);
      d_wait_out(lat);
      held = bd1.codeword;
      check("bp_first", held, ref_cw(m));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_codeword", bd1.codeword, held);
         check("bp_out_valid", 63'(bd1.out_valid), 63'(1));
         check("bp_in_ready", 63'(bd1.in_ready), 63'(0));
      end
      bd1.out_ready = 1'b1;
      check("bp_in_ready_pre", 63'(bd1.in_ready), 63'(0));
      @(negedge clk);
      check("bp_in_ready_post", 63'(bd1.in_ready), 63'(1));
      check("bp_out_valid_post", 63'(bd1.out_valid), 63'(0));

      // reset in the middle of an encode (cnt==30)
      m = {24'($urandom), $urandom};
      d_accept(m);
      repeat (30) @(negedge clk);
      check("pre_rst_busy", 63'(bd1.busy), 63'(1));
      rst_d = 1'b1;
      dq1.delete();
      @(negedge clk);
      check("mid_rst_in_ready", 63'(bd1.in_ready), 63'(1));
      check("mid_rst_out_valid", 63'(bd1.out_valid), 63'(0));
      check("mid_rst_busy", 63'(bd1.busy), 63'(0));
      rst_d = 1'b0;
      seen  = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (bd1.out_valid) seen++;
      end
      check("post_rst_quiet", 63'(seen), 63'(0));
      m = {24'($urandom), $urandom};
      d_accept(m);
      d_wait_out(lat);
      check("lat_after_rst", 63'(lat), 63'(56));

`ifdef BCH_ERR_INJECT_EN
      bd1.err_en  = 1'b1;
      bd1.err_pos = 6'd0;
      d_accept(56'h1);
      d_wait_out(lat);
      check("inj_pos0", bd1.codeword, 63'h0C4);
      bd1.err_pos = 6'd63;
      d_accept(56'h1);
      d_wait_out(lat);
      check("inj_pos63", bd1.codeword, 63'h0C5);
      bd1.err_en  = 1'b0;
      bd1.err_pos = 6'd0;
`endif
      repeat (3) @(negedge clk);

      waited = 0;
      while (lanes_done < 5 && waited < 90000) begin
         @(negedge clk);
         waited++;
      end
      if (lanes_done < 5) begin
         checks++;
         errors++;
         $display("FAIL lanes_timeout: %0d lanes done, expected 5", lanes_done);
      end
      check("d1_queue_drained", 63'(dq1.size()), 63'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
